// File: rtl/memtowb.sv
// MEM stage of the five-stage MIPS pipeline: word-addressed data RAM with a
// multi-cycle access FSM, branch resolution, pipeline flush and the MEM/WB register.
module memtowb #(
  parameter int DEPTH_LOG2 = 8,
  parameter int MEM_LAT    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exmregwrite,
  input  logic        exmmemtoreg,
  input  logic        exmmemwrite,
  input  logic        exmbranch,
  input  logic        exmbgtz,
  input  logic [7:0]  addresult,
  input  logic [31:0] exmaluresult,
  input  logic [31:0] exmr2_dout,
  input  logic [4:0]  exmrd,
  output logic        pcsrc,
  output logic [7:0]  branchtarget,
  output logic        flush,
  output logic        memstall,
  output logic        memwbregwrite,
  output logic        memwbmemtoreg,
  output logic [31:0] memwbreaddata,
  output logic [31:0] memwbaluresult,
  output logic [4:0]  memwbrd
);

  localparam int CW = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'((MEM_LAT >= 2) ? (MEM_LAT - 2) : 0);
  localparam bit SINGLE = (MEM_LAT == 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic access, complete, stall_raw;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0] ram [2**DEPTH_LOG2];

  assign access = exmmemtoreg | exmmemwrite;
  assign idx    = exmaluresult[DEPTH_LOG2+1:2];

  // Address bits outside the word index are deliberately ignored (wrap-around).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{exmaluresult[31:DEPTH_LOG2+2], exmaluresult[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    stall_raw = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (!access || SINGLE) begin
          complete = 1'b1;
        end else begin
          stall_raw = 1'b1;
          state_n   = BUSY;
          cnt_n     = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          stall_raw = 1'b1;
          cnt_n     = cnt - 1'b1;
        end else begin
          complete = 1'b1;
          state_n  = IDLE;
        end
      end
    endcase
  end

  // Reset must release upstream at once, even while an access is still presented.
  assign memstall     = stall_raw & ~rst;
  assign pcsrc        = exmbranch & exmbgtz & ~rst;
  assign flush        = pcsrc;
  assign branchtarget = addresult;

  always_ff @(posedge clk) begin
    if (complete && exmmemwrite && !rst) begin
      ram[idx] <= exmr2_dout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      memwbregwrite  <= 1'b0;
      memwbmemtoreg  <= 1'b0;
      memwbreaddata  <= '0;
      memwbaluresult <= '0;
      memwbrd        <= '0;
    end else if (complete) begin
      memwbregwrite  <= exmregwrite;
      memwbmemtoreg  <= exmmemtoreg;
      memwbreaddata  <= exmmemtoreg ? ram[idx] : 32'h0;
      memwbaluresult <= exmaluresult;
      memwbrd        <= exmrd;
    end else begin
      memwbregwrite  <= 1'b0;
      memwbmemtoreg  <= 1'b0;
      memwbreaddata  <= '0;
      memwbaluresult <= '0;
      memwbrd        <= '0;
    end
  end

endmodule

// File: tb/tb_memtowb.sv
// Scoreboard bench for memtowb: one instance with MEM_LAT=2 and one with MEM_LAT=4
// share the stimulus; sel4 picks which instance is being observed.
module tb_memtowb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exmregwrite = 0, exmmemtoreg = 0, exmmemwrite = 0;
  logic        exmbranch = 0, exmbgtz = 0;
  logic [7:0]  addresult = 0;
  logic [31:0] exmaluresult = 0, exmr2_dout = 0;
  logic [4:0]  exmrd = 0;

  logic        pc2, fl2, st2, rw2, mt2, pc4, fl4, st4, rw4, mt4;
  logic [7:0]  bt2, bt4;
  logic [31:0] rdat2, alu2, rdat4, alu4;
  logic [4:0]  rd2, rd4;

  bit sel4 = 1'b0;
  logic        oPcsrc, oFlush, oStall, oRw, oMtr;
  logic [7:0]  oTarget;
  logic [31:0] oRdata, oAlu;
  logic [4:0]  oRd;

  assign oPcsrc  = sel4 ? pc4   : pc2;
  assign oFlush  = sel4 ? fl4   : fl2;
  assign oStall  = sel4 ? st4   : st2;
  assign oRw     = sel4 ? rw4   : rw2;
  assign oMtr    = sel4 ? mt4   : mt2;
  assign oTarget = sel4 ? bt4   : bt2;
  assign oRdata  = sel4 ? rdat4 : rdat2;
  assign oAlu    = sel4 ? alu4  : alu2;
  assign oRd     = sel4 ? rd4   : rd2;

  memtowb #(.DEPTH_LOG2(8), .MEM_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .exmregwrite(exmregwrite), .exmmemtoreg(exmmemtoreg),
    .exmmemwrite(exmmemwrite), .exmbranch(exmbranch), .exmbgtz(exmbgtz),
    .addresult(addresult), .exmaluresult(exmaluresult), .exmr2_dout(exmr2_dout),
    .exmrd(exmrd), .pcsrc(pc2), .branchtarget(bt2), .flush(fl2), .memstall(st2),
    .memwbregwrite(rw2), .memwbmemtoreg(mt2), .memwbreaddata(rdat2),
    .memwbaluresult(alu2), .memwbrd(rd2));

  memtowb #(.DEPTH_LOG2(8), .MEM_LAT(4)) dut4 (
    .clk(clk), .rst(rst), .exmregwrite(exmregwrite), .exmmemtoreg(exmmemtoreg),
    .exmmemwrite(exmmemwrite), .exmbranch(exmbranch), .exmbgtz(exmbgtz),
    .addresult(addresult), .exmaluresult(exmaluresult), .exmr2_dout(exmr2_dout),
    .exmrd(exmrd), .pcsrc(pc4), .branchtarget(bt4), .flush(fl4), .memstall(st4),
    .memwbregwrite(rw4), .memwbmemtoreg(mt4), .memwbreaddata(rdat4),
    .memwbaluresult(alu4), .memwbrd(rd4));

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw;
    logic        mtr;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  rd;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] modelMem [256];
  bit          written  [256];
  int compared = 0;
  int mismatched = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkBubble();
    checkOutput("bubble_flags", {30'd0, oRw, oMtr}, 32'd0);
    checkOutput("bubble_rdata", oRdata, 32'd0);
    checkOutput("bubble_alu", oAlu, 32'd0);
    checkOutput("bubble_rd", {27'd0, oRd}, 32'd0);
  endtask

  task automatic driveNop();
    exmregwrite = 0; exmmemtoreg = 0; exmmemwrite = 0;
    exmbranch = 0; exmbgtz = 0; addresult = 0;
    exmaluresult = 0; exmr2_dout = 0; exmrd = 0;
  endtask

  // One instruction through the stage: drive, push expectation, walk its cycles.
  task automatic applyStimulus(input logic rw, input logic mtr, input logic mw,
                               input logic br, input logic bg, input logic [7:0] tgt,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic [4:0] rd);
    exp_t e;
    int   lat;
    int   w;
    @(negedge clk);
    exmregwrite = rw; exmmemtoreg = mtr; exmmemwrite = mw;
    exmbranch = br; exmbgtz = bg; addresult = tgt;
    exmaluresult = addr; exmr2_dout = data; exmrd = rd;
    w   = int'(addr[9:2]);
    lat = (mtr | mw) ? (sel4 ? 4 : 2) : 1;
    e.rw = rw; e.mtr = mtr; e.alu = addr; e.rd = rd;
    e.rdata = mtr ? modelMem[w] : 32'd0;
    if (mw) begin
      modelMem[w] = data;
      written[w]  = 1'b1;
    end
    sb.push_back(e);
    #1;
    checkOutput("pcsrc", {31'd0, oPcsrc}, {31'd0, br & bg});
    checkOutput("flush", {31'd0, oFlush}, {31'd0, br & bg});
    checkOutput("branchtarget", {24'd0, oTarget}, {24'd0, tgt});
    for (int c = 1; c <= lat; c++) begin
      if (c > 1) begin
        @(negedge clk);
        #1;
      end
      checkOutput("memstall", {31'd0, oStall}, (c < lat) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
      if (c < lat) begin
        checkBubble();
      end else if (sb.size() == 0) begin
        checkOutput("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("memwbregwrite", {31'd0, oRw}, {31'd0, e.rw});
        checkOutput("memwbmemtoreg", {31'd0, oMtr}, {31'd0, e.mtr});
        checkOutput("memwbreaddata", oRdata, e.rdata);
        checkOutput("memwbaluresult", oAlu, e.alu);
        checkOutput("memwbrd", {27'd0, oRd}, {27'd0, e.rd});
      end
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int k;
    int r;

    @(posedge clk);
    #1;
    checkOutput("reset_memstall", {31'd0, oStall}, 32'd0);
    checkBubble();
    @(negedge clk);
    rst = 1'b0;

    // MEM_LAT=2 scenarios
    applyStimulus(0, 0, 1, 0, 0, 8'h00, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0);
    applyStimulus(1, 1, 0, 0, 0, 8'h00, 32'h0000_0010, 32'h0, 5'd5);
    applyStimulus(1, 1, 0, 0, 0, 8'h00, 32'h0000_0410, 32'h0, 5'd6);
    applyStimulus(1, 0, 0, 0, 0, 8'h00, 32'h0000_1234, 32'h0, 5'd3);
    applyStimulus(0, 0, 0, 1, 1, 8'h3C, 32'h0000_0080, 32'h0, 5'd2);
    applyStimulus(0, 0, 0, 1, 0, 8'h3C, 32'h0000_0084, 32'h0, 5'd2);

    for (int i = 0; i < 10; i++) begin
      r = int'($urandom_range(0, 2));
      k = int'($urandom_range(0, 3));
      a = 32'h40 + 32'(k * 4) + (32'($urandom_range(0, 7)) << 10);
      d = $urandom;
      if (r == 0)
        applyStimulus(0, 0, 1, 0, 0, 8'h00, a, d, 5'd0);
      else if (r == 1 && written[int'(a[9:2])])
        applyStimulus(1, 1, 0, 0, 0, 8'h00, a, 32'h0, 5'(k + 8));
      else
        applyStimulus(1'($urandom), 0, 0, 1'($urandom), 1'($urandom),
                      8'($urandom), d, 32'h0, 5'($urandom));
    end

    // Asynchronous reset in the middle of a load stall
    applyStimulus(1, 0, 0, 0, 0, 8'h00, 32'h0000_0055, 32'h0, 5'd7);
    @(negedge clk);
    exmregwrite = 1; exmmemtoreg = 1; exmaluresult = 32'h10; exmrd = 5'd9;
    #1;
    checkOutput("pre_reset_stall", {31'd0, oStall}, 32'd1);
    checkOutput("pre_reset_alu", oAlu, 32'h55);
    #1 rst = 1'b1;
    #1;
    checkOutput("async_reset_stall", {31'd0, oStall}, 32'd0);
    checkOutput("async_reset_pcsrc", {31'd0, oPcsrc}, 32'd0);
    checkBubble();
    @(negedge clk);
    driveNop();
    rst = 1'b0;

    // MEM_LAT=4 scenarios
    sel4 = 1'b1;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    applyStimulus(0, 0, 1, 0, 0, 8'h00, 32'h0000_0020, 32'h1111_1111, 5'd0);
    @(negedge clk);
    exmmemwrite = 1; exmaluresult = 32'h20; exmr2_dout = 32'h2222_2222;
    #1;
    checkOutput("lat4_stall1", {31'd0, oStall}, 32'd1);
    @(negedge clk);
    #1;
    checkOutput("lat4_stall2", {31'd0, oStall}, 32'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("lat4_reset_stall", {31'd0, oStall}, 32'd0);
    #1;
    driveNop();
    rst = 1'b0;
    applyStimulus(1, 1, 0, 0, 0, 8'h00, 32'h0000_0020, 32'h0, 5'd4);
    applyStimulus(1, 0, 0, 1, 1, 8'h10, 32'h0000_0099, 32'h0, 5'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
